// File: rtl/ifetch_pkg.sv
// Shared types and helpers for the queued instruction fetch stage.
package ifetch_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Default queue entry at XLEN=32; wider builds declare their own entry type.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Power-of-two FIFO with a synchronous flush.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module ifetch_fifo
   import ifetch_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = fetch_entry_t
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    push,
   input  entry_t                  push_data,
   input  logic                    pop,
   output entry_t                  head,
   output logic                    empty,
   output logic [clog2(DEPTH):0]   count
);

   localparam int AW = clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   entry_t mem [DEPTH];
   logic [AW:0] wptr;
   logic [AW:0] rptr;
   logic        full;
   logic        do_push;
   logic        do_pop;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign count   = wptr - rptr;
   assign head    = mem[rptr[AW-1:0]];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + PTR_ONE;
         if (do_pop)  rptr <= rptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/ifetch_queue_stage.sv
// Decoupled fetch stage: credit-limited imem requests, tag FIFO, instruction queue, decode register.
// Define IFETCH_MISALIGN_CHK_EN to add MisalignD and trap misaligned redirect targets.
module ifetch_queue_stage
   import ifetch_pkg::*;
#(
   parameter int               XLEN      = 32,
   parameter logic [XLEN-1:0]  RESET_PC  = '0,
   parameter int               QDEPTH    = 4,
   parameter int               MAX_OUTST = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              PCSrcE,
   input  logic [XLEN-1:0]   PCTargetE,
   input  logic              StallD,
   output logic              imem_req,
   output logic [XLEN-1:0]   imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       InstrD,
   output logic [XLEN-1:0]   PCD,
   output logic [XLEN-1:0]   PCPlus4D,
`ifdef IFETCH_MISALIGN_CHK_EN
   output logic              MisalignD,
`endif
   output logic              ValidD
);

   localparam int CW = clog2(QDEPTH) + 1;
   localparam logic [CW:0]   QD_C  = (CW + 1)'(QDEPTH);
   localparam logic [CW-1:0] MO_C  = CW'(MAX_OUTST);
   localparam logic [CW-1:0] ONE_C = CW'(1);
   localparam logic [XLEN-1:0] FOUR = XLEN'(4);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
   } entry_t;

   logic [XLEN-1:0] pcf;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] tag_head;
   logic [CW-1:0]   q_count;
   logic [CW-1:0]   t_count;
   logic [CW-1:0]   drop;
   logic [CW-1:0]   outst;
   entry_t          q_head;
   entry_t          q_in;
   logic            q_empty;
   logic            t_empty;
   logic            fire;
   logic            live_rsp;
   logic            keep;
   logic            tag_pop;
   logic            pop_q;
   logic            halted;
   logic            mis_load;

   // Every in-flight request is either tagged (will be kept) or counted in drop.
   assign outst     = t_count + drop;
   assign live_rsp  = imem_rvalid && (drop == '0);
   assign keep      = live_rsp && !PCSrcE;
   assign tag_pop   = live_rsp && !t_empty;
   assign pop_q     = !PCSrcE && !StallD && !q_empty && !mis_load;
   assign q_in      = '{pc: tag_head, instr: imem_rdata};

   assign imem_addr = pcf;
   assign imem_req  = !reset && !PCSrcE && !halted && (outst < MO_C) &&
                      (({1'b0, q_count} + {1'b0, outst}) < QD_C);
   assign fire      = imem_req && imem_gnt;

`ifdef IFETCH_MISALIGN_CHK_EN
   logic mis_pend;

   assign target   = PCTargetE;
   assign mis_load = mis_pend;

   // A misaligned redirect parks fetch until the next redirect and reports once at D.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         halted    <= 1'b0;
         mis_pend  <= 1'b0;
         MisalignD <= 1'b0;
      end else if (PCSrcE) begin
         halted    <= |PCTargetE[1:0];
         mis_pend  <= |PCTargetE[1:0];
         MisalignD <= 1'b0;
      end else if (!StallD) begin
         MisalignD <= mis_pend;
         mis_pend  <= 1'b0;
      end
   end
`else
   assign target   = PCTargetE & ~XLEN'(3);
   assign halted   = 1'b0;
   assign mis_load = 1'b0;
`endif

   ifetch_fifo #(
      .DEPTH   (QDEPTH),
      .entry_t (logic [XLEN-1:0])
   ) u_tag_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (PCSrcE),
      .push      (fire),
      .push_data (pcf),
      .pop       (tag_pop),
      .head      (tag_head),
      .empty     (t_empty),
      .count     (t_count)
   );

   ifetch_fifo #(
      .DEPTH   (QDEPTH),
      .entry_t (entry_t)
   ) u_instr_q (
      .clk       (clk),
      .reset     (reset),
      .flush     (PCSrcE),
      .push      (keep),
      .push_data (q_in),
      .pop       (pop_q),
      .head      (q_head),
      .empty     (q_empty),
      .count     (q_count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcf  <= RESET_PC;
         drop <= '0;
      end else if (PCSrcE) begin
         pcf  <= target;
         drop <= outst - CW'(imem_rvalid);
      end else begin
         if (fire) pcf <= pcf + FOUR;
         if (imem_rvalid && (drop != '0)) drop <= drop - ONE_C;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ValidD   <= 1'b0;
         InstrD   <= NOP_INSTR;
         PCD      <= '0;
         PCPlus4D <= '0;
      end else if (PCSrcE) begin
         ValidD   <= 1'b0;
         InstrD   <= NOP_INSTR;
      end else if (!StallD) begin
         if (mis_load) begin
            ValidD   <= 1'b1;
            InstrD   <= NOP_INSTR;
            PCD      <= pcf;
            PCPlus4D <= pcf + FOUR;
         end else if (!q_empty) begin
            ValidD   <= 1'b1;
            InstrD   <= q_head.instr;
            PCD      <= q_head.pc;
            PCPlus4D <= q_head.pc + FOUR;
         end else begin
            ValidD   <= 1'b0;
            InstrD   <= NOP_INSTR;
         end
      end
   end

endmodule

// File: tb/tb_ifetch_queue_stage.sv
// Randomized bench: imem model with in-order variable latency, scoreboard of expected D loads.
// Misaligned redirect targets are only generated when IFETCH_MISALIGN_CHK_EN is undefined.
module tb_ifetch_queue_stage;
   import ifetch_pkg::*;

   localparam logic [31:0] RST_PC    = 32'h100;
   localparam int          QDEPTH    = 4;
   localparam int          MAX_OUTST = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        StallD;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
   logic        ValidD;
`ifdef IFETCH_MISALIGN_CHK_EN
   logic        MisalignD;
`endif

   always #5 clk = ~clk;

   ifetch_queue_stage #(
      .XLEN      (32),
      .RESET_PC  (RST_PC),
      .QDEPTH    (QDEPTH),
      .MAX_OUTST (MAX_OUTST)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .PCSrcE      (PCSrcE),
      .PCTargetE   (PCTargetE),
      .StallD      (StallD),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .InstrD      (InstrD),
      .PCD         (PCD),
      .PCPlus4D    (PCPlus4D),
`ifdef IFETCH_MISALIGN_CHK_EN
      .MisalignD   (MisalignD),
`endif
      .ValidD      (ValidD)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          dropped;
   } pend_t;

   pend_t        pend[$];
   fetch_entry_t sb[$];
   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   int live_pend  = 0;
   int arr_now    = 0;
   logic [31:0] model_pc;
   int p_gnt, p_rv, p_stall, p_redir, lat_extra;
   bit force_redir, force_stall;
   logic [31:0] force_tgt;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endfunction

   task automatic rst_check();
      chk("rst_ValidD", 32'(ValidD), 32'd0);
      chk("rst_InstrD", InstrD, NOP_INSTR);
      chk("rst_PCD", PCD, 32'd0);
      chk("rst_PCPlus4D", PCPlus4D, 32'd0);
      chk("rst_imem_req", 32'(imem_req), 32'd0);
   endtask

   // Expected D register: loads happen only on non-stalled, non-redirect edges,
   // and only entries whose response arrived before that edge are eligible.
   logic        exp_vd;
   logic [31:0] exp_pc;
   logic [31:0] exp_in;

   always @(posedge clk) begin : monitor
      bit rs, rd, ld;
      int qc;
      fetch_entry_t e;
      rs = reset;
      rd = PCSrcE;
      ld = !StallD && !rd && !rs;
      qc = sb.size() - live_pend - arr_now;
      #2;
      if (rs || rd) exp_vd = 1'b0;
      else if (ld) begin
         if (qc > 0) begin
            e      = sb.pop_front();
            exp_vd = 1'b1;
            exp_pc = e.pc;
            exp_in = e.instr;
         end else begin
            exp_vd = 1'b0;
         end
      end
      chk("ValidD", 32'(ValidD), 32'(exp_vd));
      if (exp_vd) begin
         chk("PCD", PCD, exp_pc);
         chk("InstrD", InstrD, exp_in);
         chk("PCPlus4D", PCPlus4D, exp_pc + 32'd4);
      end else begin
         chk("InstrD_bubble", InstrD, NOP_INSTR);
      end
`ifdef IFETCH_MISALIGN_CHK_EN
      chk("MisalignD", 32'(MisalignD), 32'd0);
`endif
   end

   task automatic step();
      pend_t p;
      bit redir, exp_req;
      int qcnt;
      logic [31:0] r;
      @(negedge clk);
      cyc++;
      qcnt  = sb.size() - live_pend;
      redir = force_redir || ($urandom_range(0, 99) < p_redir);
      r     = force_redir ? force_tgt : $urandom;
`ifdef IFETCH_MISALIGN_CHK_EN
      r[1:0] = 2'b00;
`endif
      exp_req     = !redir && (pend.size() < MAX_OUTST) && ((qcnt + pend.size()) < QDEPTH);
      PCSrcE      = redir;
      PCTargetE   = r;
      StallD      = force_stall || ($urandom_range(0, 99) < p_stall);
      imem_gnt    = ($urandom_range(0, 99) < p_gnt);
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      arr_now     = 0;
      if (pend.size() > 0 && pend[0].due <= cyc && $urandom_range(0, 99) < p_rv) begin
         p           = pend.pop_front();
         imem_rvalid = 1'b1;
         imem_rdata  = instr_of(p.addr);
         if (!p.dropped) begin
            live_pend--;
            arr_now = redir ? 0 : 1;
         end
      end
      #1;
      chk("imem_req", 32'(imem_req), 32'(exp_req));
      if (exp_req && imem_gnt) begin
         chk("imem_addr", imem_addr, model_pc);
         p.addr    = model_pc;
         p.due     = cyc + 1 + $urandom_range(0, lat_extra);
         p.dropped = 1'b0;
         pend.push_back(p);
         sb.push_back('{pc: model_pc, instr: instr_of(model_pc)});
         live_pend++;
         model_pc = model_pc + 32'd4;
      end
      if (redir) begin
         sb.delete();
         foreach (pend[i]) pend[i].dropped = 1'b1;
         live_pend = 0;
         model_pc  = {r[31:2], 2'b00};
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset       = 1'b1;
      PCSrcE      = 1'b0;
      StallD      = 1'b0;
      imem_gnt    = 1'b1;
      imem_rvalid = 1'b1;
      arr_now     = 0;
      #1;
      rst_check();
      pend.delete();
      sb.delete();
      live_pend = 0;
      model_pc  = RST_PC;
      repeat (2) @(negedge clk);
      reset       = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
   endtask

   task automatic redirect_to(input logic [31:0] t);
      force_redir = 1'b1;
      force_tgt   = t;
      step();
      force_redir = 1'b0;
   endtask

   initial begin
      reset = 1'b1; PCSrcE = 1'b0; PCTargetE = '0; StallD = 1'b0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      force_redir = 1'b0; force_stall = 1'b0; force_tgt = '0;
      model_pc = RST_PC;
      p_gnt = 100; p_rv = 100; p_stall = 0; p_redir = 0; lat_extra = 0;
      repeat (3) @(negedge clk);
      rst_check();
      reset = 1'b0;

      repeat (20) step();

      force_stall = 1'b1;
      repeat (8) step();
      force_stall = 1'b0;
      repeat (10) step();

      lat_extra = 3;
      for (int i = 0; i < 20 && pend.size() < 2; i++) step();
      redirect_to(32'h200);
      lat_extra = 0;
      repeat (15) step();

      redirect_to(32'h402);
      repeat (12) step();

      redirect_to(32'hFFFF_FFF4);
      repeat (15) step();

      repeat (3) step();
      do_reset();
      repeat (15) step();

      p_gnt = 70; p_rv = 70; p_stall = 30; p_redir = 4; lat_extra = 3;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         else step();
      end

      p_redir = 0; p_stall = 0; p_rv = 100;
      repeat (20) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
